// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and default parameter values for the PWM bank.
//               pwm_mode_e selects edge- or center-aligned counting and
//               pwm_dir_e is the state of the center-mode up/down FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int unsigned c_DEF_NUM_CH = 4;
    localparam int unsigned c_DEF_CNT_W  = 16;
    localparam int unsigned c_DEF_PSC_W  = 8;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
// Module      : pwm_channel
// Description : One PWM output. Compares the shared period counter with the
//               channel duty and registers the polarity-adjusted level.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (output forced to 0)
//               i_cnt   - current period counter value
//               i_duty  - active duty value for this channel
//               i_run   - global enable AND channel enable
//               i_pol   - polarity; also the level driven while not running
//               o_pwm   - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_run,
    input  logic             i_pol,
    output logic             o_pwm
);

    logic w_raw;
    logic w_level;
    logic r_pwm;

    // Unsigned compare: duty 0 never asserts, duty above the period always does.
    assign w_raw   = (i_cnt < i_duty);
    assign w_level = i_run ? (w_raw ^ i_pol) : i_pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_level;
        end
    end

    assign o_pwm = r_pwm;

endmodule : pwm_channel

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
// Module      : pwm_bank
// Description : Bank of NUM_CH PWM channels sharing one prescaler and one
//               period counter. Period, mode and duties are double-buffered:
//               load writes the shadow copy, which moves to the active copy
//               at the next period boundary (or every cycle while disabled).
// Ports       : clk, reset       - clock / synchronous active-high reset
//               enable           - global run control
//               prescale         - counter advances every prescale+1 clocks
//               period, mode,
//               duty             - shadow values captured on load
//               load             - one-cycle shadow write strobe
//               ch_en, polarity  - per-channel enable and output inversion
//               pwm_out          - registered PWM outputs
//               period_end       - one-cycle pulse after each boundary
//               update_pending   - shadow written but not yet active
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = c_DEF_NUM_CH,
    parameter int unsigned CNT_W  = c_DEF_CNT_W,
    parameter int unsigned PSC_W  = c_DEF_PSC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PSC_W-1:0]        prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic                    mode,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       polarity,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_end,
    output logic                    update_pending
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Prescaler
    logic [PSC_W-1:0]        r_psc_cnt;
    logic [PSC_W-1:0]        w_psc_nxt;
    logic                    w_tick;

    // Counter / direction FSM
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_inc;
    pwm_dir_e                r_dir;
    pwm_dir_e                w_dir_nxt;
    logic                    w_boundary;

    // Shadow and active configuration
    logic [CNT_W-1:0]        r_period_s;
    logic [CNT_W-1:0]        r_period_a;
    pwm_mode_e               r_mode_s;
    pwm_mode_e               r_mode_a;
    logic [NUM_CH*CNT_W-1:0] r_duty_s;
    logic [NUM_CH*CNT_W-1:0] r_duty_a;
    logic [CNT_W-1:0]        w_period_s_nxt;
    pwm_mode_e               w_mode_s_nxt;
    logic [NUM_CH*CNT_W-1:0] w_duty_s_nxt;

    logic                    r_upd_pend;
    logic                    r_period_end;
    logic                    w_transfer;

    // ------------------------------------------------------------------
    // Prescaler. A prescale reduced below the running count restarts the
    // count at 0 without producing a tick.
    // ------------------------------------------------------------------
    assign w_tick = enable && (r_psc_cnt == prescale);

    always_comb begin
        w_psc_nxt = r_psc_cnt + 1'b1;
        if (!enable || (r_psc_cnt >= prescale)) begin
            w_psc_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Counter next state. In center mode the direction register reflects
    // the direction of the next step: it turns DOWN as the counter reaches
    // period_a, and UP again at the boundary step from 1 to 0.
    // ------------------------------------------------------------------
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_boundary = 1'b0;
        if (!enable) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_tick) begin
            if (r_mode_a == PWM_EDGE) begin
                if (r_cnt == r_period_a) begin
                    w_boundary = 1'b1;
                    w_cnt_nxt  = '0;
                    w_dir_nxt  = DIR_UP;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                end
            end else begin
                if (r_period_a == '0) begin
                    w_boundary = 1'b1;
                    w_cnt_nxt  = '0;
                    w_dir_nxt  = DIR_UP;
                end else if (r_dir == DIR_UP) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_period_a) begin
                        w_dir_nxt = DIR_DOWN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        w_boundary = 1'b1;
                        w_dir_nxt  = DIR_UP;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir <= DIR_UP;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shadow / active registers. A load on the boundary cycle defers the
    // transfer so the just-written values get a full period of notice.
    // While disabled the active copy tracks the (post-load) shadow value.
    // ------------------------------------------------------------------
    assign w_period_s_nxt = load ? period : r_period_s;
    assign w_mode_s_nxt   = load ? pwm_mode_e'(mode) : r_mode_s;
    assign w_duty_s_nxt   = load ? duty : r_duty_s;
    assign w_transfer     = w_boundary && r_upd_pend && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_psc_cnt    <= '0;
            r_cnt        <= '0;
            r_period_s   <= '0;
            r_period_a   <= '0;
            r_mode_s     <= PWM_EDGE;
            r_mode_a     <= PWM_EDGE;
            r_duty_s     <= '0;
            r_duty_a     <= '0;
            r_upd_pend   <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_psc_cnt  <= w_psc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_period_s <= w_period_s_nxt;
            r_mode_s   <= w_mode_s_nxt;
            r_duty_s   <= w_duty_s_nxt;
            if (!enable) begin
                r_period_a   <= w_period_s_nxt;
                r_mode_a     <= w_mode_s_nxt;
                r_duty_a     <= w_duty_s_nxt;
                r_upd_pend   <= 1'b0;
                r_period_end <= 1'b0;
            end else begin
                if (w_transfer) begin
                    r_period_a <= r_period_s;
                    r_mode_a   <= r_mode_s;
                    r_duty_a   <= r_duty_s;
                end
                r_upd_pend   <= load || (r_upd_pend && !w_boundary);
                r_period_end <= w_boundary;
            end
        end
    end

    assign period_end     = r_period_end;
    assign update_pending = r_upd_pend;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (reset),
            .i_cnt  (r_cnt),
            .i_duty (r_duty_a[i*CNT_W +: CNT_W]),
            .i_run  (enable & ch_en[i]),
            .i_pol  (polarity[i]),
            .o_pwm  (pwm_out[i])
        );
    end

endmodule : pwm_bank

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// ============================================================================
// Module      : tb_pwm_bank
// Description : Directed self-checking bench for pwm_bank (4 ch, 16-bit
//               counter, 8-bit prescaler). Inputs change 1 time unit after
//               a rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic        mode;
    logic [63:0] duty;
    logic        load;
    logic [3:0]  ch_en;
    logic [3:0]  polarity;
    logic [3:0]  pwm_out;
    logic        period_end;
    logic        update_pending;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_bank #(
        .NUM_CH (4),
        .CNT_W  (16),
        .PSC_W  (8)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .prescale       (prescale),
        .period         (period),
        .mode           (mode),
        .duty           (duty),
        .load           (load),
        .ch_en          (ch_en),
        .polarity       (polarity),
        .pwm_out        (pwm_out),
        .period_end     (period_end),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Disable, load a configuration while idle, then enable. The caller's
    // next cyc() returns after the first counting edge (index k = 0).
    task automatic restart(input logic [15:0] per, input logic md,
                           input logic [63:0] dt, input logic [7:0] psc);
        enable = 1'b0;
        cyc();
        period   = per;
        mode     = md;
        duty     = dt;
        prescale = psc;
        load     = 1'b1;
        cyc();
        load   = 1'b0;
        enable = 1'b1;
    endtask

    int         cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    logic [15:0] exp_duty;
    logic        exp_pend;

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        load     = 1'b1;
        prescale = 8'd0;
        period   = 16'd5;
        mode     = 1'b0;
        duty     = {4{16'd3}};
        ch_en    = 4'hF;
        polarity = 4'hF;

        // Reset dominates load and enable
        cyc();
        cyc();
        check_val("rst_pwm",  32'(pwm_out), 32'h0);
        check_val("rst_pe",   32'(period_end), 32'h0);
        check_val("rst_pend", 32'(update_pending), 32'h0);
        reset    = 1'b0;
        load     = 1'b0;
        enable   = 1'b0;
        polarity = 4'h0;

        // Edge: period 9, duty0 3 -> high for counter 0..2, boundary at 9
        ch_en = 4'b0001;
        restart(16'd9, 1'b0, {16'd0, 16'd0, 16'd0, 16'd3}, 8'd0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            check_val($sformatf("edge_pwm0 k=%0d", k), 32'(pwm_out[0]), 32'((k % 10) < 3));
            check_val($sformatf("edge_pe k=%0d", k), 32'(period_end), 32'((k % 10) == 9));
        end

        // Center: period 4, duty1 2 -> counter 0,1,2,3,4,3,2,1, boundary at 1 down
        ch_en = 4'b0011;
        restart(16'd4, 1'b1, {16'd0, 16'd0, 16'd2, 16'd0}, 8'd0);
        for (int k = 0; k < 24; k++) begin
            cyc();
            check_val($sformatf("ctr_pwm1 k=%0d", k), 32'(pwm_out[1]), 32'(cseq[k % 8] < 2));
            check_val($sformatf("ctr_pwm0 k=%0d", k), 32'(pwm_out[0]), 32'h0);
            check_val($sformatf("ctr_pe k=%0d", k), 32'(period_end), 32'((k % 8) == 7));
        end

        // Shadow: mid-period load of duty 7 takes effect after the boundary;
        // a load on the boundary cycle (counter 9) waits a whole period.
        ch_en = 4'b0001;
        restart(16'd9, 1'b0, {16'd0, 16'd0, 16'd0, 16'd3}, 8'd0);
        for (int k = 0; k < 40; k++) begin
            cyc();
            exp_duty = (k < 10) ? 16'd3 : ((k < 30) ? 16'd7 : 16'd2);
            exp_pend = ((k >= 5) && (k <= 8)) || ((k >= 19) && (k <= 28));
            check_val($sformatf("shd_pwm0 k=%0d", k), 32'(pwm_out[0]), 32'(16'(k % 10) < exp_duty));
            check_val($sformatf("shd_pend k=%0d", k), 32'(update_pending), 32'(exp_pend));
            if (k == 4) begin
                duty = {16'd0, 16'd0, 16'd0, 16'd7};
                load = 1'b1;
            end else if (k == 18) begin
                duty = {16'd0, 16'd0, 16'd0, 16'd2};
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;

        // Extremes: duty0 0 never active, duty1 10 > period 9 always active,
        // disabled channels drive their polarity bit.
        ch_en    = 4'b0011;
        polarity = 4'b0000;
        restart(16'd9, 1'b0, {16'd0, 16'd0, 16'd10, 16'd0}, 8'd0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            check_val($sformatf("ext_pos k=%0d", k), 32'(pwm_out), 32'b0010);
        end
        polarity = 4'b0111;
        for (int k = 0; k < 12; k++) begin
            cyc();
            check_val($sformatf("ext_inv k=%0d", k), 32'(pwm_out), 32'b0101);
        end

        // Prescaler 3, period 1 -> 2 ticks of 4 clocks -> period_end every 8
        ch_en    = 4'b0001;
        polarity = 4'b0100;
        restart(16'd1, 1'b0, {16'd0, 16'd0, 16'd0, 16'd1}, 8'd3);
        for (int k = 0; k < 31; k++) begin
            cyc();
            check_val($sformatf("psc_pe k=%0d", k), 32'(period_end), 32'((k % 8) == 7));
            check_val($sformatf("psc_pend k=%0d", k), 32'(update_pending), 32'((k == 29) || (k == 30)));
            load = (k == 28);
        end
        load = 1'b0;

        // Reset on what would be the boundary edge: no pulse, all cleared
        reset = 1'b1;
        cyc();
        check_val("mid_rst_pwm",  32'(pwm_out), 32'h0);
        check_val("mid_rst_pe",   32'(period_end), 32'h0);
        check_val("mid_rst_pend", 32'(update_pending), 32'h0);
        reset = 1'b0;

        // Active period is now 0: boundary on every prescaled tick, counting
        // restarts with the prescaler at 0.
        for (int j = 0; j < 16; j++) begin
            cyc();
            check_val($sformatf("post_rst_pe j=%0d", j), 32'(period_end), 32'((j % 4) == 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_bank

`default_nettype wire
